// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter sequence monitor.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int CNT_W_DEF  = 4;
  localparam int STAT_W_DEF = 8;

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Saturating statistics counter; clear beats increment, reset beats both.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] value_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i)
      value_d = '0;
    else if (inc_i && (value_q != MAX))
      value_d = value_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/counter_monitor.sv
// Watches an up-counter: locks after one confirmed increment, then flags
// every out-of-sequence sample and counts violations and max->0 wraps.
module counter_monitor
  import counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [CNT_W-1:0]  Q,
  input  logic              CLR_CNT,
  output logic              LOCKED,
  output logic              ERR,
  output logic [STAT_W-1:0] ERR_CNT,
  output logic [STAT_W-1:0] WRAP_CNT,
  output logic [CNT_W-1:0]  EXP
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] nxt;
  logic             match, viol, wrap;

  assign nxt   = p_q + CNT_W'(1);
  assign match = (Q == nxt);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    err_d   = 1'b0;
    viol    = 1'b0;
    wrap    = 1'b0;
    if (!EN) begin
      state_d = IDLE;
    end else begin
      // P always follows the sampled value, so a violation reseeds from Q.
      p_d = Q;
      case (state_q)
        IDLE:  state_d = SYNC;
        SYNC:  state_d = match ? TRACK : SYNC;
        TRACK: begin
          if (match) begin
            state_d = TRACK;
            wrap    = (p_q == CNT_MAX);
          end else begin
            state_d = SYNC;
            viol    = 1'b1;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (viol),
    .clr_i  (CLR_CNT),
    .value_o(ERR_CNT)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (wrap),
    .clr_i  (CLR_CNT),
    .value_o(WRAP_CNT)
  );

  assign LOCKED = (state_q == TRACK);
  assign ERR    = err_q;
  assign EXP    = (state_q == IDLE) ? '0 : nxt;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor with hand-computed expectations.
module tb_counter_monitor;

  logic       CLK = 1'b0;
  logic       RST, EN, CLR_CNT;
  logic [3:0] Q;
  logic       LOCKED, ERR;
  logic [7:0] ERR_CNT, WRAP_CNT;
  logic [3:0] EXP;

  int checks = 0;
  int errors = 0;
  int err_seen;

  counter_monitor #(.CNT_W(4), .STAT_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .Q       (Q),
    .CLR_CNT (CLR_CNT),
    .LOCKED  (LOCKED),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT),
    .WRAP_CNT(WRAP_CNT),
    .EXP     (EXP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Apply one sample, then look at registered outputs just after the edge.
  task automatic step(input logic en, input logic [3:0] q, input logic clr);
    EN = en; Q = q; CLR_CNT = clr;
    @(posedge CLK);
    #1;
    if (ERR) err_seen++;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; Q = 4'd7; CLR_CNT = 1'b1; err_seen = 0;
    @(posedge CLK); #1;
    chk("rst_locked", LOCKED, 0);
    chk("rst_err", ERR, 0);
    chk("rst_errcnt", ERR_CNT, 0);
    chk("rst_wrapcnt", WRAP_CNT, 0);
    chk("rst_exp", EXP, 0);
    RST = 1'b0;

    // Lock-in on 3,4,5,6
    step(1, 4'd3, 0);
    chk("sync_locked", LOCKED, 0);
    chk("sync_exp", EXP, 4);
    step(1, 4'd4, 0);
    chk("lock_after4", LOCKED, 1);
    step(1, 4'd5, 0);
    step(1, 4'd6, 0);
    chk("exp_after6", EXP, 7);
    chk("lock_err", err_seen, 0);

    // Wrap 14,15,0,1
    for (int v = 7; v <= 15; v++) step(1, 4'(v), 0);
    step(1, 4'd0, 0);
    chk("wrap_cnt1", WRAP_CNT, 1);
    step(1, 4'd1, 0);
    chk("wrap_locked", LOCKED, 1);
    chk("wrap_noerr", err_seen, 0);

    // Jump 5 -> 9
    for (int v = 2; v <= 5; v++) step(1, 4'(v), 0);
    step(1, 4'd9, 0);
    chk("jump_err", ERR, 1);
    chk("jump_errcnt", ERR_CNT, 1);
    chk("jump_locked", LOCKED, 0);
    chk("jump_exp", EXP, 10);
    step(1, 4'd10, 0);
    chk("jump_errpulse", ERR, 0);
    chk("jump_relock", LOCKED, 1);

    // EN=0 drop, then stall at 8
    step(0, 4'd3, 0);
    chk("en0_locked", LOCKED, 0);
    chk("en0_exp", EXP, 0);
    chk("en0_errcnt", ERR_CNT, 1);
    chk("en0_wrapcnt", WRAP_CNT, 1);
    step(1, 4'd7, 0);
    chk("en0_nolock", LOCKED, 0);
    step(1, 4'd8, 0);
    chk("stall_pre_locked", LOCKED, 1);
    step(1, 4'd8, 0);
    chk("stall_err", ERR, 1);
    chk("stall_errcnt", ERR_CNT, 2);
    chk("stall_locked", LOCKED, 0);
    step(1, 4'd9, 0);
    chk("stall_errpulse", ERR, 0);
    chk("stall_relock", LOCKED, 1);

    // Build ERR_CNT=3, WRAP_CNT=2, EN pulse and RST mid-TRACK
    for (int v = 10; v <= 15; v++) step(1, 4'(v), 0);
    step(1, 4'd0, 0);
    chk("wrap_cnt2", WRAP_CNT, 2);
    step(1, 4'd5, 0);
    chk("viol3_errcnt", ERR_CNT, 3);
    step(1, 4'd6, 0);
    chk("pre_en_locked", LOCKED, 1);
    step(0, 4'd7, 0);
    chk("enpulse_locked", LOCKED, 0);
    chk("enpulse_errcnt", ERR_CNT, 3);
    chk("enpulse_wrapcnt", WRAP_CNT, 2);
    step(1, 4'd1, 0);
    step(1, 4'd2, 0);
    chk("pre_rst_locked", LOCKED, 1);
    RST = 1'b1;
    step(1, 4'd3, 1);
    chk("midrst_locked", LOCKED, 0);
    chk("midrst_err", ERR, 0);
    chk("midrst_errcnt", ERR_CNT, 0);
    chk("midrst_wrapcnt", WRAP_CNT, 0);
    chk("midrst_exp", EXP, 0);
    RST = 1'b0;
    step(1, 4'd3, 0);
    chk("postrst_nolock", LOCKED, 0);
    step(1, 4'd4, 0);
    chk("postrst_lock", LOCKED, 1);

    // 260 violations: alternating 0,1 gives one violation per pair
    for (int i = 0; i < 260; i++) begin
      step(1, 4'd0, 0);
      step(1, 4'd1, 0);
    end
    chk("sat_errcnt", ERR_CNT, 255);
    chk("sat_wrapcnt", WRAP_CNT, 0);
    chk("sat_locked", LOCKED, 1);
    step(1, 4'd0, 1);
    chk("clrviol_err", ERR, 1);
    chk("clrviol_errcnt", ERR_CNT, 0);
    chk("clrviol_locked", LOCKED, 0);
    step(1, 4'd1, 0);
    chk("clrviol_relock", LOCKED, 1);

    // Clear coincident with a wrap
    for (int v = 2; v <= 15; v++) step(1, 4'(v), 0);
    step(1, 4'd0, 0);
    chk("pre_clrwrap_cnt", WRAP_CNT, 1);
    for (int v = 1; v <= 15; v++) step(1, 4'(v), 0);
    step(1, 4'd0, 1);
    chk("clrwrap_wrapcnt", WRAP_CNT, 0);
    chk("clrwrap_locked", LOCKED, 1);
    chk("clrwrap_err", ERR, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
